// File: rtl/fitness_collector.sv
// Fitness collector: gathers one frame of upstream values into a packed array, kicks
// the sorter, and waits (bounded) for it to finish before accepting the next frame.
// Frames longer than INPUTVALS beats are truncated and their tail is drained.
module fitness_collector #(
  parameter int unsigned INPUTVALS      = 16,
  parameter int unsigned INPUTBITWIDTHS = 32,
  parameter int unsigned TIMEOUT        = 1024
) (
  input  logic                                         clk,
  input  logic                                         reset,
  input  logic                                         in_valid,
  input  logic [INPUTBITWIDTHS-1:0]                    in_data,
  input  logic                                         in_last,
  output logic                                         in_ready,
  output logic                                         sortstart,
  output logic [INPUTVALS-1:0][INPUTBITWIDTHS-1:0]     needs_sorting,
  output logic [$clog2(INPUTVALS):0]                   valid_count,
  input  logic                                         sortdone,
  output logic                                         frame_done,
  output logic                                         overrun,
  output logic                                         error
);

  localparam int unsigned VcW  = $clog2(INPUTVALS) + 1;
  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    StFill  = 2'd0,
    StStart = 2'd1,
    StWait  = 2'd2,
    StDrain = 2'd3
  } state_e;

  state_e                                   state_q, state_d;
  logic [INPUTVALS-1:0][INPUTBITWIDTHS-1:0] slots_q, slots_d;
  logic [VcW-1:0]                           count_q, count_d;
  logic [CntW-1:0]                          wait_q, wait_d;
  logic                                     drain_q, drain_d;
  logic                                     frame_done_q, frame_done_d;
  logic                                     overrun_q, overrun_d;
  logic                                     error_q, error_d;
  logic                                     accept;
  logic                                     enter_fill;
  logic                                     frame_full;

  assign accept     = in_valid && in_ready;
  assign frame_full = (count_q == VcW'(INPUTVALS - 1));

  // Next-state, datapath updates and state-decoded outputs.
  always_comb begin
    state_d      = state_q;
    slots_d      = slots_q;
    count_d      = count_q;
    wait_d       = wait_q;
    drain_d      = drain_q;
    frame_done_d = 1'b0;
    overrun_d    = 1'b0;
    error_d      = 1'b0;
    enter_fill   = 1'b0;
    sortstart    = 1'b0;
    in_ready     = 1'b0;

    case (state_q)
      StFill: begin
        in_ready = 1'b1;
        if (accept) begin
          for (int unsigned i = 0; i < INPUTVALS; i++) begin
            if (count_q == VcW'(i)) slots_d[i] = in_data;
          end
          count_d = count_q + VcW'(1);
          if (in_last || frame_full) begin
            state_d = StStart;
          end
          // Frame hit capacity without its last beat: flag it and drop the tail later.
          if (frame_full && !in_last) begin
            overrun_d = 1'b1;
            drain_d   = 1'b1;
          end
        end
      end
      StStart: begin
        sortstart = 1'b1;
        wait_d    = '0;
        state_d   = StWait;
      end
      StWait: begin
        wait_d = wait_q + CntW'(1);
        if (sortdone) begin
          frame_done_d = 1'b1;
          if (drain_q) state_d = StDrain;
          else         enter_fill = 1'b1;
        end else if (wait_q == CntW'(TIMEOUT - 1)) begin
          error_d = 1'b1;
          if (drain_q) state_d = StDrain;
          else         enter_fill = 1'b1;
        end
      end
      StDrain: begin
        in_ready = 1'b1;
        if (accept && in_last) begin
          drain_d    = 1'b0;
          enter_fill = 1'b1;
        end
      end
      default: begin
        error_d    = 1'b1;
        drain_d    = 1'b0;
        enter_fill = 1'b1;
      end
    endcase

    // Unfilled slots read as all-ones so they sort to the top.
    if (enter_fill) begin
      state_d = StFill;
      slots_d = '1;
      count_d = '0;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StFill;
      slots_q      <= '1;
      count_q      <= '0;
      wait_q       <= '0;
      drain_q      <= 1'b0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      slots_q      <= slots_d;
      count_q      <= count_d;
      wait_q       <= wait_d;
      drain_q      <= drain_d;
      frame_done_q <= frame_done_d;
      overrun_q    <= overrun_d;
      error_q      <= error_d;
    end
  end

  assign needs_sorting = slots_q;
  assign valid_count   = count_q;
  assign frame_done    = frame_done_q;
  assign overrun       = overrun_q;
  assign error         = error_q;

endmodule

// File: tb/tb_fitness_collector.sv
// Directed bench for fitness_collector (4 slots x 8 bits, timeout 8) with a frame scoreboard.
module tb_fitness_collector;

  localparam int unsigned N  = 4;
  localparam int unsigned W  = 8;
  localparam int unsigned TO = 8;

  logic               clk = 1'b0;
  logic               reset;
  logic               in_valid;
  logic [W-1:0]       in_data;
  logic               in_last;
  logic               in_ready;
  logic               sortstart;
  logic [N-1:0][W-1:0] needs_sorting;
  logic [2:0]         valid_count;
  logic               sortdone;
  logic               frame_done;
  logic               overrun;
  logic               error;

  typedef struct {
    logic [31:0] frame;
    logic [2:0]  count;
    logic        ov;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;

  fitness_collector #(
    .INPUTVALS      (N),
    .INPUTBITWIDTHS (W),
    .TIMEOUT        (TO)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_data       (in_data),
    .in_last       (in_last),
    .in_ready      (in_ready),
    .sortstart     (sortstart),
    .needs_sorting (needs_sorting),
    .valid_count   (valid_count),
    .sortdone      (sortdone),
    .frame_done    (frame_done),
    .overrun       (overrun),
    .error         (error)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; sample point is 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one beat and hold it until the DUT takes it (bounded).
  task automatic send(input logic [W-1:0] d, input logic l);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    check("send_ready", in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic push(input logic [31:0] f, input logic [2:0] c, input logic ov);
    exp_t e;
    e.frame = f;
    e.count = c;
    e.ov    = ov;
    sb.push_back(e);
  endtask

  // Called in the START cycle: compare the captured frame against the oldest expectation.
  task automatic expect_start();
    exp_t e;
    check("sortstart", sortstart, 1'b1);
    check("start_ready", in_ready, 1'b0);
    check("sb_nonempty", (sb.size() > 0), 1'b1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("frame", needs_sorting, e.frame);
      check("valid_count", valid_count, e.count);
      check("overrun", overrun, e.ov);
    end
  endtask

  task automatic expect_idle_fill();
    check("fill_ready", in_ready, 1'b1);
    check("fill_slots", needs_sorting, 32'hFFFF_FFFF);
    check("fill_count", valid_count, 3'd0);
  endtask

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    in_last  = 1'b0;
    sortdone = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    // Reset values
    expect_idle_fill();
    check("rst_sortstart", sortstart, 1'b0);
    check("rst_frame_done", frame_done, 1'b0);
    check("rst_overrun", overrun, 1'b0);
    check("rst_error", error, 1'b0);

    // sortdone outside WAIT has no effect
    sortdone = 1'b1;
    tick();
    sortdone = 1'b0;
    tick();
    check("idle_sortdone_fd", frame_done, 1'b0);

    // Full frame, sortdone in the third WAIT cycle
    push(32'h4433_2211, 3'd4, 1'b0);
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    send(8'h33, 1'b0);
    send(8'h44, 1'b1);
    expect_start();
    tick();
    check("wait_sortstart_gone", sortstart, 1'b0);
    check("wait_hold_frame", needs_sorting, 32'h4433_2211);
    tick();
    tick();
    sortdone = 1'b1;
    tick();
    sortdone = 1'b0;
    check("full_frame_done", frame_done, 1'b1);
    check("full_no_error", error, 1'b0);
    expect_idle_fill();
    tick();
    check("frame_done_one_cycle", frame_done, 1'b0);

    // Short frame
    push(32'hFFFF_0905, 3'd2, 1'b0);
    send(8'h05, 1'b0);
    send(8'h09, 1'b1);
    expect_start();
    tick();
    sortdone = 1'b1;
    tick();
    sortdone = 1'b0;
    check("short_frame_done", frame_done, 1'b1);
    expect_idle_fill();

    // Overlong frame: truncate, overrun, drain the tail
    push(32'hA4A3_A2A1, 3'd4, 1'b1);
    send(8'hA1, 1'b0);
    send(8'hA2, 1'b0);
    send(8'hA3, 1'b0);
    send(8'hA4, 1'b0);
    expect_start();
    tick();
    check("overrun_one_cycle", overrun, 1'b0);
    sortdone = 1'b1;
    tick();
    sortdone = 1'b0;
    check("ovr_frame_done", frame_done, 1'b1);
    check("drain_ready", in_ready, 1'b1);
    send(8'hA5, 1'b0);
    check("drain_slots_kept", valid_count, 3'd4);
    send(8'hA6, 1'b1);
    expect_idle_fill();
    check("drain_no_fd", frame_done, 1'b0);

    // Single-beat frame, then sortdone never arrives
    push(32'hFFFF_FF77, 3'd1, 1'b0);
    send(8'h77, 1'b1);
    expect_start();
    tick();
    for (int i = 0; i < int'(TO); i++) begin
      check("to_no_error_yet", error, 1'b0);
      tick();
    end
    check("timeout_error", error, 1'b1);
    check("timeout_no_fd", frame_done, 1'b0);
    expect_idle_fill();
    tick();
    check("error_one_cycle", error, 1'b0);

    // Reset mid-frame discards the partial frame silently
    send(8'hB1, 1'b0);
    send(8'hB2, 1'b0);
    check("partial_count", valid_count, 3'd2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    expect_idle_fill();
    check("rst2_overrun", overrun, 1'b0);
    check("rst2_error", error, 1'b0);
    check("rst2_sortstart", sortstart, 1'b0);

    // Next frame starts at slot 0; a beat held through START/WAIT waits for FILL
    push(32'hFFFF_C2C1, 3'd2, 1'b0);
    push(32'hFFFF_FFC3, 3'd1, 1'b0);
    send(8'hC1, 1'b0);
    send(8'hC2, 1'b1);
    expect_start();
    in_valid = 1'b1;
    in_data  = 8'hC3;
    in_last  = 1'b1;
    tick();
    tick();
    check("held_not_ready", in_ready, 1'b0);
    check("held_frame_stable", needs_sorting, 32'hFFFF_C2C1);
    check("held_count_stable", valid_count, 3'd2);
    sortdone = 1'b1;
    tick();
    sortdone = 1'b0;
    check("held_frame_done", frame_done, 1'b1);
    expect_idle_fill();
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
    expect_start();
    tick();
    sortdone = 1'b1;
    tick();
    sortdone = 1'b0;
    check("last_frame_done", frame_done, 1'b1);
    check("sb_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
